// File: rtl/toggle_seq_pkg.sv
// Shared state encoding and default widths for the toggle sequencer.
// Every file that needs these imports this package.
package toggle_seq_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int DIV_W_DEF = 26;
    localparam int IDX_W_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/toggle_seq_ctrl_if.sv
// Control and status bundle of the toggle sequencer.
// The controller uses the slave modport and the pattern source uses the master modport.
interface toggle_seq_ctrl_if
    import toggle_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) ();

    logic             start;
    logic             stop;
    logic             loop;
    logic [DIV_W-1:0] div;
    logic [PAT_W-1:0] pattern;
    logic             Q;
    logic             tick;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output start, stop, loop, div, pattern,
        input  Q, tick, busy, done, bit_idx
    );

    modport slave (
        input  start, stop, loop, div, pattern,
        output Q, tick, busy, done, bit_idx
    );

endinterface

// File: rtl/tick_gen.sv
// Programmable divider that emits a one-cycle tick every div_q enabled cycles.
// The tick is decoded combinationally from the counter, so it adds no latency.
module tick_gen
    import toggle_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_q,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // div_q is never zero here, because the controller maps zero to one when it latches the divisor.
    assign tick = en && (cnt == div_q - DIV_W'(1));

    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Pattern player that feeds one latched T bit per divider tick into a T flip-flop.
// Supports one-shot and looping runs, aborting with stop, and a one-cycle done pulse.
module toggle_seq_ctrl
    import toggle_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input logic              clk,
    input logic              rst,
    toggle_seq_ctrl_if.slave bus
);

    state_e           state;
    logic [PAT_W-1:0] pattern_q;
    logic [DIV_W-1:0] div_q;
    logic             loop_q;
    logic             q_r;
    logic             busy_r;
    logic [IDX_W-1:0] bit_idx_r;
    logic             tick;
    logic             last_bit;

    // The counter is held at zero outside RUN, so every run starts with a fresh count.
    tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state == S_RUN),
        .clr   ((state != S_RUN) || bus.stop),
        .div_q (div_q),
        .tick  (tick)
    );

    assign last_bit    = (bit_idx_r == IDX_W'(PAT_W - 1));
    assign bus.tick    = tick;
    assign bus.done    = (state == S_DONE);
    assign bus.Q       = q_r;
    assign bus.busy    = busy_r;
    assign bus.bit_idx = bit_idx_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            q_r       <= 1'b0;
            busy_r    <= 1'b0;
            bit_idx_r <= '0;
            pattern_q <= '0;
            div_q     <= DIV_W'(1);
            loop_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        pattern_q <= bus.pattern;
                        div_q     <= (bus.div == '0) ? DIV_W'(1) : bus.div;
                        loop_q    <= bus.loop;
                        bit_idx_r <= '0;
                        busy_r    <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // stop wins over a coincident tick, so that tick's toggle is dropped.
                    if (bus.stop) begin
                        bit_idx_r <= '0;
                        busy_r    <= 1'b0;
                        state     <= S_IDLE;
                    end else if (tick) begin
                        if (pattern_q[bit_idx_r]) begin
                            q_r <= ~q_r;
                        end
                        if (last_bit) begin
                            bit_idx_r <= '0;
                            if (!loop_q) begin
                                busy_r <= 1'b0;
                                state  <= S_DONE;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Self-checking bench for toggle_seq_ctrl.
// Expected outputs come from closed-form arithmetic on cycle numbers relative to start acceptance.
module tb_toggle_seq_ctrl;

    localparam int PAT_W = 8;
    localparam int DIV_W = 26;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   q_model  = 1'b0;

    toggle_seq_ctrl_if #(.PAT_W(PAT_W), .DIV_W(DIV_W), .IDX_W(IDX_W)) bus ();

    toggle_seq_ctrl #(.PAT_W(PAT_W), .DIV_W(DIV_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check_idle(input string name, input bit exp_q);
        n_checks++;
        if (bus.Q !== exp_q || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.tick !== 1'b0 || bus.bit_idx !== '0) begin
            n_errors++;
            $display("FAIL %s: got Q=%b busy=%b done=%b tick=%b bit_idx=%0d, expected Q=%b busy=0 done=0 tick=0 bit_idx=0",
                     name, bus.Q, bus.busy, bus.done, bus.tick, bus.bit_idx, exp_q);
        end
    endtask

    // One start-accepted run. stop_at is the cycle in which stop is held high; 0 means no stop.
    // With disturb set, start stays high and the config inputs change while the run is in progress.
    task automatic run_seq(input string name, input logic [PAT_W-1:0] pat, input logic [DIV_W-1:0] dv,
                           input bit lp, input int stop_at, input bit disturb);
        int d, end_c, ncyc, kc, idx;
        bit stopped, in_run, e_q, e_tick, e_done;
        int e_idx;
        bit q0;
        d     = (dv == 0) ? 1 : int'(dv);
        end_c = PAT_W * d;
        ncyc  = (stop_at > 0) ? stop_at + 3 : end_c + 3;
        q0    = q_model;
        e_q   = q0;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.stop    = 1'b0;
        bus.pattern = pat;
        bus.div     = dv;
        bus.loop    = lp;

        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            stopped = (stop_at > 0) && (n > stop_at);
            in_run  = !stopped && (lp || n <= end_c);
            kc      = stopped ? (stop_at - 1) / d : (n - 1) / d;
            if (!lp && kc > PAT_W) kc = PAT_W;
            e_q = q0;
            for (int k = 0; k < kc; k++) begin
                idx = k % PAT_W;
                e_q = e_q ^ pat[idx];
            end
            e_tick = in_run && (n % d == 0);
            e_idx  = in_run ? ((n - 1) / d) % PAT_W : 0;
            e_done = !stopped && !lp && (n == end_c + 1);

            n_checks++;
            if (bus.Q !== e_q) begin
                n_errors++;
                $display("FAIL %s Q cycle %0d: got %b expected %b", name, n, bus.Q, e_q);
            end
            n_checks++;
            if (bus.tick !== e_tick) begin
                n_errors++;
                $display("FAIL %s tick cycle %0d: got %b expected %b", name, n, bus.tick, e_tick);
            end
            n_checks++;
            if (bus.busy !== in_run) begin
                n_errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, n, bus.busy, in_run);
            end
            n_checks++;
            if (bus.done !== e_done) begin
                n_errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, n, bus.done, e_done);
            end
            n_checks++;
            if (int'(bus.bit_idx) !== e_idx) begin
                n_errors++;
                $display("FAIL %s bit_idx cycle %0d: got %0d expected %0d", name, n, bus.bit_idx, e_idx);
            end

            bus.start = disturb && (n <= end_c + 1);
            bus.stop  = (n == stop_at);
            if (disturb && n == 1) begin
                bus.pattern = '0;
                bus.div     = DIV_W'($urandom_range(0, 7));
                bus.loop    = ~lp;
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        q_model   = e_q;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        bus.div     = DIV_W'(1);
        bus.pattern = PAT_W'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset_hold", 1'b0);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_idle("reset_release", 1'b0);
        q_model = 1'b0;
    endtask

    task automatic test_one_shot_fast();
        run_seq("one_shot_div1", 8'b1010_1010, DIV_W'(1), 1'b0, 0, 1'b0);
    endtask

    task automatic test_slow_all_ones();
        run_seq("slow_div3_ff", 8'hFF, DIV_W'(3), 1'b0, 0, 1'b0);
    endtask

    task automatic test_div_zero();
        run_seq("div0", 8'b1010_1010, DIV_W'(0), 1'b0, 0, 1'b0);
    endtask

    task automatic test_loop_stop();
        // Cycle 50 is the 25th tick, which consumes bit 0, so the suppressed toggle is observable.
        run_seq("loop_stop", 8'h01, DIV_W'(2), 1'b1, 50, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_seq("ignored_inputs", 8'b0110_1101, DIV_W'(2), 1'b0, 0, 1'b1);
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check_idle("stop_in_idle", q_model);
    endtask

    task automatic test_mid_run_reset();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.div     = DIV_W'(1);
        bus.loop    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_run_reset", 1'b0);
        q_model = 1'b0;
        @(negedge clk);
        check_idle("after_mid_run_reset", 1'b0);
    endtask

    task automatic test_random_runs();
        logic [PAT_W-1:0] pat;
        logic [DIV_W-1:0] dv;
        bit lp;
        int d, s;
        for (int r = 0; r < 8; r++) begin
            pat = PAT_W'($urandom);
            dv  = DIV_W'($urandom_range(0, 4));
            lp  = 1'($urandom_range(0, 1));
            d   = (dv == 0) ? 1 : int'(dv);
            if (lp) s = $urandom_range(1, 40);
            else    s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, PAT_W * d) : 0;
            run_seq("random", pat, dv, lp, s, 1'b0);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        bus.div     = '0;
        bus.pattern = '0;
        test_reset();
        test_one_shot_fast();
        test_slow_all_ones();
        test_div_zero();
        test_loop_stop();
        test_ignored_inputs();
        test_mid_run_reset();
        test_random_runs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
